// File: rtl/count_seg_pkg.sv
// count_seg_pkg: shared widths, segment bit order and hex font for the count display
package count_seg_pkg;
  localparam int COUNT_W = 4;
  localparam int DP_STRETCH_DEF = 8;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/count_seg_if.sv
// count_seg_if: count input, display controls and display outputs of count_seg_driver
interface count_seg_if;
  import count_seg_pkg::*;
  logic [COUNT_W-1:0] count_in;
  logic               hold;
  logic               sel;
  logic               clear;
  logic [6:0]         seg_out;
  logic               dp_out;
  logic [COUNT_W-1:0] wrap_cnt;
  modport master (output count_in, hold, sel, clear, input seg_out, dp_out, wrap_cnt);
  modport slave  (input count_in, hold, sel, clear, output seg_out, dp_out, wrap_cnt);
endinterface

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex-font decode, output order {g,f,e,d,c,b,a}, active-high
module hex_to_seg7
  import count_seg_pkg::*;
(
  input  logic [COUNT_W-1:0] i_hex,
  output logic [6:0]         o_seg
);
  logic [6:0] w_row;
  // table lookup, then place each segment at its named bit position
  always_comb begin
    w_row = SEG_TABLE[i_hex];
    o_seg = {w_row[SEG_G], w_row[SEG_F], w_row[SEG_E], w_row[SEG_D],
             w_row[SEG_C], w_row[SEG_B], w_row[SEG_A]};
  end
endmodule

// File: rtl/count_seg_driver.sv
// count_seg_driver: samples a 4-bit count, drives a 7-seg digit and a stretched wrap indicator
// Optional wrap detection / wrap counter / dp pulse / sel / clear under COUNT_SEG_WRAP_EN.
module count_seg_driver
  import count_seg_pkg::*;
#(
  parameter int DP_STRETCH = DP_STRETCH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  count_seg_if.slave  bus
);
  localparam logic [7:0] DP_LOAD = 8'(DP_STRETCH);
  logic [COUNT_W-1:0] r_cnt;
  logic [COUNT_W-1:0] r_prev;
  logic [6:0]         r_seg;
  logic [COUNT_W-1:0] w_disp;
  logic [6:0]         w_seg;
  // sample the count and keep the previous sample; both freeze while hold is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_prev <= '0;
    end else if (!bus.hold) begin
      r_prev <= r_cnt;
      r_cnt  <= bus.count_in;
    end
  end
  hex_to_seg7 u_dec (
    .i_hex (w_disp),
    .o_seg (w_seg)
  );
  // register the decoded digit so seg_out trails its source by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_seg <= '0;
    else        r_seg <= w_seg;
  end
  assign bus.seg_out = r_seg;
`ifdef COUNT_SEG_WRAP_EN
  logic [COUNT_W-1:0] r_wrap;
  logic [7:0]         r_timer;
  logic               w_wrap;
  // a wrap is an F followed by 0 in the sample pair, seen on an edge that takes a new sample
  always_comb w_wrap = !bus.hold && r_prev == 4'hF && r_cnt == 4'h0;
  // wrap counter and retriggerable dp timer; clear overrides a same-edge wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap  <= '0;
      r_timer <= '0;
    end else if (bus.clear) begin
      r_wrap  <= '0;
      r_timer <= '0;
    end else begin
      r_wrap  <= w_wrap ? r_wrap + 4'd1 : r_wrap;
      r_timer <= w_wrap ? DP_LOAD : r_timer - {7'b0, |r_timer};
    end
  end
  assign w_disp       = bus.sel ? r_wrap : r_cnt;
  assign bus.wrap_cnt = r_wrap;
  assign bus.dp_out   = r_timer != 8'd0;
`else
  logic w_unused;
  assign w_unused     = ^{bus.sel, bus.clear, r_prev, DP_LOAD};
  assign w_disp       = r_cnt;
  assign bus.wrap_cnt = '0;
  assign bus.dp_out   = 1'b0;
`endif
endmodule

// File: tb/tb_count_seg_driver.sv
// tb_count_seg_driver: directed self-checking bench for count_seg_driver
module tb_count_seg_driver;
  logic clk;
  logic rst_n;
  int checks;
  int errors;
  logic [6:0] exp_seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  count_seg_if bus ();

  count_seg_driver #(.DP_STRETCH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    bus.count_in = 4'h5;
    bus.hold = 1'b0;
    bus.sel = 1'b0;
    bus.clear = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.seg_out !== 7'h00) begin errors++; $display("FAIL reset_seg: got %h expected %h", bus.seg_out, 7'h00); end
    checks++;
    if (bus.dp_out !== 1'b0) begin errors++; $display("FAIL reset_dp: got %b expected 0", bus.dp_out); end
    checks++;
    if (bus.wrap_cnt !== 4'h0) begin errors++; $display("FAIL reset_wrap: got %h expected 0", bus.wrap_cnt); end
    bus.count_in = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.seg_out !== 7'h3F) begin errors++; $display("FAIL reset_first_digit: got %h expected %h", bus.seg_out, 7'h3F); end
    tick();
    checks++;
    if (bus.wrap_cnt !== 4'h0 || bus.dp_out !== 1'b0) begin
      errors++; $display("FAIL reset_no_wrap: got wrap %h dp %b expected 0 0", bus.wrap_cnt, bus.dp_out);
    end
  endtask

  task automatic test_count;
    for (int i = 0; i < 17; i++) begin
      bus.count_in = (i < 16) ? 4'(i) : 4'hF;
      tick();
      if (i >= 1) begin
        checks++;
        if (bus.seg_out !== exp_seg[i-1]) begin
          errors++; $display("FAIL count_digit_%0d: got %h expected %h", i - 1, bus.seg_out, exp_seg[i-1]);
        end
      end
    end
    checks++;
    if (bus.wrap_cnt !== 4'h0) begin errors++; $display("FAIL count_wrap: got %h expected 0", bus.wrap_cnt); end
  endtask

  task automatic test_wrap;
    int n;
    do_clear();
    bus.count_in = 4'hE; tick();
    bus.count_in = 4'hF; tick();
    bus.count_in = 4'h0; tick();
    checks++;
    if (bus.dp_out !== 1'b0 || bus.wrap_cnt !== 4'h0) begin
      errors++; $display("FAIL wrap_early: got dp %b wrap %h expected 0 0", bus.dp_out, bus.wrap_cnt);
    end
    bus.count_in = 4'h1; tick();
    checks++;
    if (bus.wrap_cnt !== 4'h1) begin errors++; $display("FAIL wrap_cnt_one: got %h expected 1", bus.wrap_cnt); end
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.dp_out === 1'b1) n++;
      tick();
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL wrap_dp_len: got %0d expected 8", n); end
    checks++;
    if (bus.wrap_cnt !== 4'h1) begin errors++; $display("FAIL wrap_single: got %h expected 1", bus.wrap_cnt); end
    bus.sel = 1'b1;
    tick();
    checks++;
    if (bus.seg_out !== 7'h06) begin errors++; $display("FAIL wrap_sel_seg: got %h expected %h", bus.seg_out, 7'h06); end
    bus.sel = 1'b0;
    tick();
    checks++;
    if (bus.seg_out !== 7'h06) begin errors++; $display("FAIL wrap_sel_back: got %h expected %h", bus.seg_out, 7'h06); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] vec [9] = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'hE, 4'hF, 4'h0, 4'h1};
    int n;
    int rises;
    logic last;
    do_clear();
    n = 0;
    rises = 0;
    last = 1'b0;
    for (int k = 0; k < 29; k++) begin
      bus.count_in = (k < 9) ? vec[k] : 4'h1;
      tick();
      if (bus.dp_out === 1'b1) n++;
      if (bus.dp_out === 1'b1 && !last) rises++;
      last = bus.dp_out;
    end
    checks++;
    if (n !== 13) begin errors++; $display("FAIL b2b_dp_len: got %0d expected 13", n); end
    checks++;
    if (rises !== 1) begin errors++; $display("FAIL b2b_dp_contig: got %0d rises expected 1", rises); end
    checks++;
    if (bus.wrap_cnt !== 4'h2) begin errors++; $display("FAIL b2b_wrap_cnt: got %h expected 2", bus.wrap_cnt); end
  endtask

  task automatic test_hold;
    do_clear();
    bus.count_in = 4'hE; tick();
    bus.count_in = 4'hF; tick();
    bus.hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.count_in = 4'((k * 7) % 16);
      tick();
      checks++;
      if (bus.seg_out !== 7'h71 || bus.wrap_cnt !== 4'h0 || bus.dp_out !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: got seg %h wrap %h dp %b expected 71 0 0", k, bus.seg_out, bus.wrap_cnt, bus.dp_out);
      end
    end
    bus.hold = 1'b0;
    bus.count_in = 4'h0;
    tick();
    tick();
    checks++;
    if (bus.wrap_cnt !== 4'h1 || bus.dp_out !== 1'b1) begin
      errors++; $display("FAIL hold_release_wrap: got wrap %h dp %b expected 1 1", bus.wrap_cnt, bus.dp_out);
    end
    tick();
    tick();
    checks++;
    if (bus.wrap_cnt !== 4'h1) begin errors++; $display("FAIL hold_single: got %h expected 1", bus.wrap_cnt); end
  endtask

  task automatic test_clear;
    do_clear();
    bus.count_in = 4'hE; tick();
    bus.count_in = 4'hF; tick();
    bus.count_in = 4'h0; tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    checks++;
    if (bus.wrap_cnt !== 4'h0 || bus.dp_out !== 1'b0) begin
      errors++; $display("FAIL clear_wins: got wrap %h dp %b expected 0 0", bus.wrap_cnt, bus.dp_out);
    end
    tick();
    checks++;
    if (bus.wrap_cnt !== 4'h0 || bus.dp_out !== 1'b0) begin
      errors++; $display("FAIL clear_after: got wrap %h dp %b expected 0 0", bus.wrap_cnt, bus.dp_out);
    end
    for (int w = 0; w < 17; w++) begin
      bus.count_in = 4'hE; tick();
      bus.count_in = 4'hF; tick();
      bus.count_in = 4'h0; tick();
      bus.count_in = 4'h1; tick();
    end
    checks++;
    if (bus.wrap_cnt !== 4'h1) begin errors++; $display("FAIL clear_mod16: got %h expected 1", bus.wrap_cnt); end
  endtask

  task automatic test_reset_mid_pulse;
    int n;
    do_clear();
    bus.count_in = 4'hE; tick();
    bus.count_in = 4'hF; tick();
    bus.count_in = 4'h0; tick();
    bus.count_in = 4'h1; tick();
    tick();
    checks++;
    if (bus.dp_out !== 1'b1) begin errors++; $display("FAIL midrst_pre_dp: got %b expected 1", bus.dp_out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dp_out !== 1'b0 || bus.wrap_cnt !== 4'h0 || bus.seg_out !== 7'h00) begin
      errors++; $display("FAIL midrst_async: got dp %b wrap %h seg %h expected 0 0 00", bus.dp_out, bus.wrap_cnt, bus.seg_out);
    end
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.dp_out === 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL midrst_no_resume: got %0d dp cycles expected 0", n); end
  endtask

  task automatic test_no_wrap;
    int n;
    bus.count_in = 4'hE; tick();
    bus.count_in = 4'hF; tick();
    bus.count_in = 4'h0; tick();
    bus.count_in = 4'h1;
    bus.sel = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.dp_out !== 1'b0 || bus.wrap_cnt !== 4'h0) n++;
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL nowrap_outputs: got %0d bad cycles expected 0", n); end
    checks++;
    if (bus.seg_out !== 7'h06) begin errors++; $display("FAIL nowrap_sel_ignored: got %h expected %h", bus.seg_out, 7'h06); end
    bus.sel = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_count();
`ifdef COUNT_SEG_WRAP_EN
    test_wrap();
    test_back_to_back();
    test_hold();
    test_clear();
    test_reset_mid_pulse();
`else
    test_no_wrap();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_seg_driver.md
COUNT_SEG_DRIVER -- requirements
Module: count_seg_driver

Interface
REQ-001 SHALL have parameter DP_STRETCH, default 8; dp_out pulse length in clk cycles; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single design clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port count_in  input  4  count value from the upstream 4-bit up-counter.
REQ-005 SHALL have port hold  input  1  1 = freeze the sampled count.
REQ-006 SHALL have port sel  input  1  display select: 0 = count, 1 = wrap count.
REQ-007 SHALL have port clear  input  1  synchronous clear of the wrap count and dp timer.
REQ-008 SHALL have port seg_out  output  7  registered segments, bit order {g,f,e,d,c,b,a}, active-high.
REQ-009 SHALL have port dp_out  output  1  registered decimal point; stretched wrap indicator.
REQ-010 SHALL have port wrap_cnt  output  4  number of detected wraps, modulo 16.

Function
REQ-011 SHALL capture count_in into cnt_q and copy the old cnt_q into prev_q on each edge with hold=0; both SHALL be unchanged while hold=1.
REQ-012 SHALL raise an internal one-cycle wrap event in any cycle where the current edge captures a new sample and prev_q==4'hF and cnt_q==4'h0; no event otherwise, including while hold=1.
REQ-013 SHALL increment wrap_cnt by 1 per wrap event, wrapping 15->0 with no saturation and no flag.
REQ-014 SHALL load the dp timer with DP_STRETCH on a wrap event; a wrap event during an active pulse SHALL reload it (retrigger); dp_out=1 while timer!=0; timer decrements by 1 per cycle to 0.
REQ-015 SHALL drive seg_out with the hex-font decode (0-9, A, b, C, d, E, F) of cnt_q when sel=0, or of wrap_cnt when sel=1, registered one edge after the selected source changes.
REQ-016 SHALL give seg_out a total latency of 2 edges from count_in to output (capture, then decode register).
REQ-017 SHALL, when clear=1, set wrap_cnt=0 and the dp timer to 0 on that edge; clear SHALL win over a simultaneous wrap event; cnt_q/prev_q are unaffected.
REQ-018 SHALL let a sel change take effect on seg_out at the next edge, with no effect on any other state.
REQ-019 SHALL detect a wrap across a hold window: held value 4'hF, then the first post-release sample 4'h0 counts as one wrap.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously force cnt_q=0, prev_q=0, wrap_cnt=0, dp timer=0, seg_out=7'h00 and dp_out=0.
REQ-021 SHALL generate no wrap event on the first sample after reset release, even if count_in=0.
REQ-022 SHALL show seg_out=7'h3F ("0") from the first edge after reset release, given sel=0.
REQ-023 SHALL apply reset mid-pulse immediately: dp_out=0, with no resumption after release.

Configuration
REQ-024 SHALL support macro COUNT_SEG_WRAP_EN; when defined, wrap detection, wrap_cnt, the dp timer, sel and clear behave as in REQ-012..REQ-019.
REQ-025 SHALL, without COUNT_SEG_WRAP_EN, tie wrap_cnt=0 and dp_out=0, ignore sel and clear, always display cnt_q, and synthesize no wrap or timer registers.

Structure
REQ-026 SHALL place in shared package count_seg_pkg: the 16-entry hex-to-segment constant table, the segment bit-order constants, COUNT_W=4, and the DP_STRETCH default.
REQ-027 SHALL have one combinational sub-module hex_to_seg7 (4-bit in, 7-bit out) using the package table; all registers stay in count_seg_driver.

Verification
REQ-028 SHALL cover: reset, then count_in stepping 0..F by 1 per cycle with sel=0 -> seg_out shows each digit 2 edges later (3->7'h4F, A->7'h77); wrap_cnt=0.
REQ-029 SHALL cover: count_in steps E,F,0 -> exactly one wrap; wrap_cnt=1; dp_out high for exactly 8 cycles; sel=1 -> seg_out=7'h06.
REQ-030 SHALL cover: two wraps 5 cycles apart (DP_STRETCH=8) -> dp_out high for 13 contiguous cycles; wrap_cnt=2.
REQ-031 SHALL cover: hold=1 at F for 10 cycles while count_in varies, release with count_in=0 -> one wrap; seg_out shows F throughout the hold.
REQ-032 SHALL cover: clear=1 on the same edge as a wrap event -> wrap_cnt=0, dp_out stays 0; 17 wraps without clear -> wrap_cnt=1.
REQ-033 SHALL cover: rst_n low for one cycle mid dp pulse -> all outputs 0 asynchronously; build without COUNT_SEG_WRAP_EN -> wrap_cnt=0 and dp_out=0 across an F->0 transition.
